// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory subsystem: FSM states,
// memory-mapped device addresses and the status bit position.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } mem_state_e;

  localparam logic [15:0] MMIO_BASE = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  localparam int unsigned STAT_BIT = 15;

endpackage

// File: rtl/lc3_mmio_regs.sv
// Keyboard/display register block (KBSR/KBDR/DSR/DDR) for the LC-3 memory
// subsystem; only instantiated when LC3_MMIO_EN is defined.
module lc3_mmio_regs
  import lc3_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [15:0] rdata,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ack
);

  logic       kbsr_q, kbsr_d;
  logic [7:0] kbdr_q, kbdr_d;
  logic       disp_valid_q, disp_valid_d;
  logic [7:0] disp_data_q, disp_data_d;
  logic       kbdr_rd, ddr_wr;

  always_comb begin
    kbsr_d       = kbsr_q;
    kbdr_d       = kbdr_q;
    disp_valid_d = disp_valid_q;
    disp_data_d  = disp_data_q;
    kbdr_rd      = rd_en && (addr == KBDR_ADDR);
    ddr_wr       = wr_en && (addr == DDR_ADDR);

    // A KBDR read frees the slot in the same edge, so a concurrent key is kept.
    if (kbdr_rd) kbsr_d = 1'b0;
    if (kbd_valid && (!kbsr_q || kbdr_rd)) begin
      kbsr_d = 1'b1;
      kbdr_d = kbd_data;
    end

    if (disp_ack) disp_valid_d = 1'b0;
    if (ddr_wr && (!disp_valid_q || disp_ack)) begin
      disp_valid_d = 1'b1;
      disp_data_d  = wdata;
    end

    rdata = '0;
    case (addr)
      KBSR_ADDR: rdata[STAT_BIT] = kbsr_q;
      KBDR_ADDR: rdata = {8'h00, kbdr_q};
      DSR_ADDR:  rdata[STAT_BIT] = ~disp_valid_q;
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kbsr_q       <= 1'b0;
      kbdr_q       <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      kbsr_q       <= kbsr_d;
      kbdr_q       <= kbdr_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;

endmodule

// File: rtl/lc3_memory_sys.sv
// Wait-stated word RAM behind a req/ready handshake for the LC-3 core.
// Define LC3_MMIO_EN to add the keyboard/display registers at 0xFE00-0xFFFF.
module lc3_memory_sys
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] memory_addr,
  input  logic [DATA_W-1:0] memory_din,
  input  logic              memWE,
`ifdef LC3_MMIO_EN
  input  logic              kbd_valid,
  input  logic [7:0]        kbd_data,
  output logic              disp_valid,
  output logic [7:0]        disp_data,
  input  logic              disp_ack,
`endif
  output logic [DATA_W-1:0] memory_dout,
  output logic              mem_ready
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] WS_LOAD  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam mem_state_e ACC_NEXT = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;

  mem_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_din, rd_word, ram_rd;
  logic              acc_we, commit, in_range, ram_we;

  // With zero wait states the access commits on the accept edge itself, so the
  // access path takes the live inputs then and the latched copy otherwise.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    din_d    = din_q;
    we_d     = we_q;
    acc_addr = addr_q;
    acc_din  = din_q;
    acc_we   = we_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 3'd1;
      end
      default: begin
        if (mem_req) begin
          state_d  = ACC_NEXT;
          cnt_d    = WS_LOAD;
          addr_d   = memory_addr;
          din_d    = memory_din;
          we_d     = memWE;
          acc_addr = memory_addr;
          acc_din  = memory_din;
          acc_we   = memWE;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
    commit = (state_d == ST_RESP);
  end

  assign in_range = 32'(acc_addr) < 32'(DEPTH);
  assign ram_rd   = ram[acc_addr[IDX_W-1:0]];

`ifdef LC3_MMIO_EN
  logic        in_mmio;
  logic [15:0] mmio_rdata;

  assign in_mmio = (acc_addr[15:9] == MMIO_BASE[15:9]);
  assign ram_we  = commit && acc_we && in_range && !in_mmio;

  lc3_mmio_regs u_mmio (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (commit && !acc_we && in_mmio),
    .wr_en      (commit && acc_we && in_mmio),
    .addr       (16'(acc_addr)),
    .wdata      (acc_din[7:0]),
    .rdata      (mmio_rdata),
    .kbd_valid  (kbd_valid),
    .kbd_data   (kbd_data),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_ack   (disp_ack)
  );
`else
  assign ram_we = commit && acc_we && in_range;
`endif

  always_comb begin
    rd_word = in_range ? ram_rd : '0;
`ifdef LC3_MMIO_EN
    if (in_mmio) rd_word = DATA_W'(mmio_rdata);
`endif
    dout_d = (commit && !acc_we) ? rd_word : dout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ram_we) ram[acc_addr[IDX_W-1:0]] <= acc_din;
  end

  assign mem_ready   = (state_q == ST_RESP);
  assign memory_dout = dout_q;

endmodule

// File: doc/lc3_memory_sys.md
# lc3_memory_sys

Parametrised memory subsystem serving the LC-3 core's memory port, replacing the fixed zero-latency memory model. It provides a word-addressed RAM with a configurable wait-state count behind a request/ready handshake. An optional memory-mapped keyboard/display register block sits at the standard LC-3 device addresses. It sits between the `lc3` core's memory signals and the testbench, on the same clock.

## Interface
Clock: one clock, `clk`. Reset: `rst`, synchronous, active-high.

Parameters:
- `DATA_W`, 16 — word width.
- `ADDR_W`, 16 — address width; must be 16 when `LC3_MMIO_EN` is defined.
- `DEPTH`, 4096 — number of backed words, located at addresses 0..DEPTH-1.
- `WAIT_STATES`, 2 — extra cycles per access; legal range 0..7.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — synchronous active-high reset.
- `mem_req` in 1 — access request, sampled only when the block can accept.
- `memory_addr` in ADDR_W — word address.
- `memory_din` in DATA_W — write data from the core.
- `memWE` in 1 — 1 = write, 0 = read; qualified by `mem_req`.
- `memory_dout` out DATA_W — read data, valid while `mem_ready`=1.
- `mem_ready` out 1 — one-cycle completion pulse.
- `kbd_valid` in 1 — keyboard character strobe (MMIO builds only).
- `kbd_data` in 8 — keyboard character (MMIO builds only).
- `disp_valid` out 1 — display character pending (MMIO builds only).
- `disp_data` out 8 — display character (MMIO builds only).
- `disp_ack` in 1 — display consumed the character (MMIO builds only).

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- Accept: in IDLE or RESP, `mem_req`=1 latches addr, din and WE.
  - Next state is WAIT if WAIT_STATES>0, else RESP.
- In IDLE or RESP with `mem_req`=0: next state is IDLE.
- WAIT: a counter loads WAIT_STATES-1 on accept and decrements each cycle; at 0 the FSM moves to RESP.
- `mem_req` is ignored in WAIT.
- Access happens on the edge entering RESP:
  - A write commits to the array.
  - A read registers the array word into `memory_dout`.
- RESP: `mem_ready`=1 for exactly one cycle.
- `memory_dout` holds its last read value until the next read RESP; writes leave it unchanged.
- Out of range (addr ≥ DEPTH and not MMIO): a read returns 0 and a write is dropped.
- MMIO (when enabled), all registers 16 bits wide:
  - 0xFE00 KBSR: bit15 = character available.
  - 0xFE02 KBDR: reads {8'h00, char} and clears KBSR[15].
  - 0xFE04 DSR: bit15 = ~`disp_valid`.
  - 0xFE06 DDR: a write sets `disp_valid` and `disp_data` = din[7:0].
  - Writes to KBSR, KBDR and DSR are ignored.
  - Other addresses in 0xFE00–0xFFFF read 0.
- Keyboard: `kbd_valid` with KBSR[15]=0 latches `kbd_data` and sets KBSR[15]. If KBSR[15]=1, the new character is dropped (overrun).
- Same cycle KBDR read commit and `kbd_valid`: the read returns the old character, and the new character is latched with KBSR[15]=1 (set wins).
- DDR write while `disp_valid`=1: dropped. `disp_ack` clears `disp_valid` the next edge.
- Same-edge DDR write and `disp_ack`: the ack clears the old character and the new one is loaded (`disp_valid` stays 1).

## Timing
- Request sampled at edge E0 → `mem_ready` high in cycle E0+WAIT_STATES+1 → latency WAIT_STATES+1.
- Throughput is one access per WAIT_STATES+1 cycles. With WAIT_STATES=0 and `mem_req` held high, `mem_ready` is high every cycle.
- Read-after-write to the same address in consecutive accesses returns the new data.
- Reset values:
  - FSM = IDLE.
  - `mem_ready`=0, `memory_dout`=0.
  - `disp_valid`=0, `disp_data`=0.
  - KBSR[15]=0, KBDR=0.
- The RAM array is not reset.
- Reset mid-access: FSM returns to IDLE and a pending uncommitted write is discarded. No `mem_ready` is issued for it.

## Configuration
- Macro: `LC3_MMIO_EN`.
- Defined: the MMIO register block and the keyboard/display ports exist, and the 0xFE00–0xFFFF window is decoded as described in Operation.
- Undefined: the keyboard/display ports are absent and all addresses are plain memory. Addresses ≥ DEPTH follow the out-of-range rule.

## Structure
- Package `lc3_mem_pkg` holds:
  - the FSM state enum (IDLE/WAIT/RESP);
  - MMIO address constants KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR and the MMIO window base;
  - the status bit index (15).
- Sub-module `lc3_mmio_regs` holds the keyboard/display registers and the KBSR/DSR logic. It is instantiated only under `LC3_MMIO_EN`.
- The top level owns the FSM, the wait counter, the array and the read mux.

## Test plan
- Reset: assert `rst` for 2 cycles → `mem_ready`=0, `memory_dout`=0x0000, `disp_valid`=0.
- WAIT_STATES=2: write 0x1234 to 0x0010 sampled at cycle 0 → `mem_ready` at cycle 3. Read of 0x0010 → `memory_dout`=0x1234 with `mem_ready` 3 cycles later.
- WAIT_STATES=0: `mem_req` held high, reads of 0x0001, 0x0002, 0x0003 on consecutive cycles (preloaded 0xA, 0xB, 0xC) → `mem_ready` on 3 consecutive cycles with 0x000A, 0x000B, 0x000C in order.
- DEPTH=4096: write 0xBEEF to 0x2000, then read 0x2000 → 0x0000.
- `LC3_MMIO_EN`:
  - `kbd_valid` with 0x41 → KBSR reads 0x8000, KBDR reads 0x0041, KBSR then reads 0x0000.
  - DDR write 0x0048 → `disp_valid`=1, `disp_data`=0x48, DSR=0x0000. After `disp_ack`, DSR=0x8000.
- Reset during WAIT of a write of 0x5555 to 0x0020 (old value 0x1111) → no `mem_ready`. A later read returns 0x1111.
